genius_sequencer: RTL and testbench
===================================

GENIUS_SEQUENCER -- requirements
Module: genius_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 16, meaning steps needed to win (2..32).
REQ-002 Parameter ON_FRAMES, default 30, meaning frames a colour is lit during playback.
REQ-003 Parameter GAP_FRAMES, default 15, meaning dark frames after each playback step and after a completed round.
REQ-004 Parameter TIMEOUT_FRAMES, default 180, meaning frames allowed per player press.
REQ-005 Parameter RESULT_FRAMES, default 120, meaning frames WIN_EN/LOSE_EN stay high.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, meaning LFSR value after reset (nonzero).
REQ-007 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-008 RESET  input  1  asynchronous, active-high reset.
REQ-009 FRAME_TICK  input  1  one-cycle pulse per VGA frame start.
REQ-010 START  input  1  one-cycle pulse that begins a game.
REQ-011 BTN  input  4  one-cycle debounced press pulses; bit0 blue, bit1 green, bit2 red, bit3 yellow.
REQ-012 BLUE_EN / GREEN_EN / RED_EN / YELLOW_EN  output  1 each  colour sprite enables.
REQ-013 LOSE_EN / WIN_EN / PWR_EN  output  1 each  result and power sprite enables.
REQ-014 LEVEL  output  6  current sequence length.

Function
REQ-015 The FSM SHALL have states IDLE, APPEND, SHOW_ON, SHOW_GAP, INPUT, ROUND_GAP, WIN, LOSE.
REQ-016 Outputs SHALL be Moore decodes of registered state and counters only, with no input-to-output combinational path.
REQ-017 A frame counter SHALL clear on every state entry and increment on FRAME_TICK; a timed state of N frames SHALL exit on the FRAME_TICK where the count equals N-1.
REQ-018 IDLE: all enables SHALL be 0; START SHALL clear len and idx and go to APPEND; START in any other state SHALL be ignored.
REQ-019 APPEND (one cycle): seq[len] SHALL take lfsr[1:0], len SHALL increment, idx SHALL clear, and the FSM SHALL go to SHOW_ON.
REQ-020 SHOW_ON: the colour enable selected by seq[idx] SHALL be 1 for ON_FRAMES, then the FSM SHALL go to SHOW_GAP.
REQ-021 SHOW_GAP: colours SHALL be off for GAP_FRAMES; idx SHALL then increment, going to SHOW_ON if idx<len, otherwise clearing idx and going to INPUT.
REQ-022 INPUT, matching press: a one-hot BTN equal to seq[idx] SHALL increment idx and restart the timeout count.
REQ-023 INPUT, round complete: when the match makes idx==len, the FSM SHALL go to WIN if len==MAX_LEN, otherwise to ROUND_GAP.
REQ-024 INPUT, failure: BTN with no match, more than one bit set, or TIMEOUT_FRAMES ticks without a press SHALL send the FSM to LOSE.
REQ-025 A press and the final timeout tick in the same cycle SHALL be judged as the press.
REQ-026 ROUND_GAP SHALL last GAP_FRAMES, then go to APPEND.
REQ-027 WIN / LOSE SHALL drive WIN_EN / LOSE_EN high for RESULT_FRAMES, then go to IDLE.
REQ-028 PWR_EN SHALL be 1 in every state except IDLE.
REQ-029 LEVEL SHALL equal len.
REQ-030 The LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11+1, and SHALL advance every clock in all states.
REQ-031 Colour encoding: 0 blue, 1 green, 2 red, 3 yellow.

Reset
REQ-032 RESET SHALL force state IDLE, len=0, idx=0, frame count=0, lfsr=LFSR_SEED and all outputs 0 immediately, without waiting for a clock edge.
REQ-033 RESET asserted mid-game SHALL abandon the game; seq contents need not be cleared.

Structure
REQ-034 Package genius_pkg SHALL hold the state encoding, the colour encoding constants and the default parameter values.
REQ-035 The LFSR SHALL be sub-module genius_lfsr (ports: clock, reset, seed, q[15:0]).
REQ-036 seq SHALL be a register array of MAX_LEN x 2 bits.

Verification (bench parameters: MAX_LEN=2, ON=2, GAP=1, TIMEOUT=5, RESULT=3, FRAME_TICK every 10 clocks)
REQ-037 Reset then START -> PWR_EN=1 one cycle after the START cycle; LEVEL=1; exactly one colour enable high for 2 ticks, then INPUT.
REQ-038 Correct press for step 1, then correct presses for steps 1-2 -> LEVEL=2; playback of 2 colours between rounds; WIN_EN=1 for 3 ticks, then all outputs 0.
REQ-039 Wrong colour press in INPUT -> LOSE_EN=1 on the next cycle for 3 ticks, then IDLE.
REQ-040 No press for 5 ticks -> LOSE; a press on the 5th tick cycle is judged as the press.
REQ-041 BTN=4'b0011 in INPUT -> LOSE; START pulsed during SHOW_ON -> no effect.
REQ-042 RESET pulsed mid-SHOW_ON -> all outputs 0 before the next clock edge; LEVEL=0; a subsequent START with identical timing reproduces an identical colour sequence.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon-style) memory game sequencer.
// Holds the FSM state encoding, the colour codes and the default timing parameters.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPEND,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_INPUT,
        ST_ROUND_GAP,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam logic [1:0] COLOUR_BLUE   = 2'd0;
    localparam logic [1:0] COLOUR_GREEN  = 2'd1;
    localparam logic [1:0] COLOUR_RED    = 2'd2;
    localparam logic [1:0] COLOUR_YELLOW = 2'd3;

    localparam int          DEF_MAX_LEN        = 16;
    localparam int          DEF_ON_FRAMES      = 30;
    localparam int          DEF_GAP_FRAMES     = 15;
    localparam int          DEF_TIMEOUT_FRAMES = 180;
    localparam int          DEF_RESULT_FRAMES  = 120;
    localparam logic [15:0] DEF_LFSR_SEED      = 16'hACE1;

    localparam int LEN_W = 6;
    localparam int CNT_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] colour_mask(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit Galois LFSR that steps every clock; it is the game's source of colours.
module genius_lfsr
    import genius_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/genius_sequencer.sv
// Game controller: grows a random colour sequence, plays it back on frame ticks,
// then checks the player's presses against it and reports win or loss.
module genius_sequencer
    import genius_pkg::*;
#(
    parameter int          MAX_LEN        = DEF_MAX_LEN,
    parameter int          ON_FRAMES      = DEF_ON_FRAMES,
    parameter int          GAP_FRAMES     = DEF_GAP_FRAMES,
    parameter int          TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
    parameter int          RESULT_FRAMES  = DEF_RESULT_FRAMES,
    parameter logic [15:0] LFSR_SEED      = DEF_LFSR_SEED
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             FRAME_TICK,
    input  logic             START,
    input  logic [3:0]       BTN,
    output logic             BLUE_EN,
    output logic             GREEN_EN,
    output logic             RED_EN,
    output logic             YELLOW_EN,
    output logic             LOSE_EN,
    output logic             WIN_EN,
    output logic             PWR_EN,
    output logic [LEN_W-1:0] LEVEL,
    output state_t           fsm_state
);

    localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state, state_n;
    logic [LEN_W-1:0]   len, len_n, idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         seq [MAX_LEN];
    logic               seq_we;
    logic [15:0]        lfsr;
    logic               lfsr_unused;
    logic [1:0]         cur_colour, show_colour;
    logic [3:0]         colour_n, colour_q;
    logic               win_q, lose_q, pwr_q;
    logic               tick_done_on, tick_done_gap, tick_done_to, tick_done_res;

    genius_lfsr u_lfsr (
        .clock (CLOCK_50),
        .reset (RESET),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:2];

    assign tick_done_on  = FRAME_TICK && (cnt == CNT_W'(ON_FRAMES - 1));
    assign tick_done_gap = FRAME_TICK && (cnt == CNT_W'(GAP_FRAMES - 1));
    assign tick_done_to  = FRAME_TICK && (cnt == CNT_W'(TIMEOUT_FRAMES - 1));
    assign tick_done_res = FRAME_TICK && (cnt == CNT_W'(RESULT_FRAMES - 1));

    assign cur_colour = seq[idx[SEL_W-1:0]];

    always_comb begin
        state_n     = state;
        len_n       = len;
        idx_n       = idx;
        seq_we      = 1'b0;
        cnt_n       = FRAME_TICK ? cnt + CNT_W'(1) : cnt;
        show_colour = 2'd0;
        colour_n    = 4'b0000;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    len_n   = '0;
                    idx_n   = '0;
                    state_n = ST_APPEND;
                end
            end
            ST_APPEND: begin
                seq_we  = 1'b1;
                len_n   = len + LEN_W'(1);
                idx_n   = '0;
                state_n = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tick_done_on) state_n = ST_SHOW_GAP;
            end
            ST_SHOW_GAP: begin
                if (tick_done_gap) begin
                    if (idx + LEN_W'(1) < len) begin
                        idx_n   = idx + LEN_W'(1);
                        state_n = ST_SHOW_ON;
                    end else begin
                        idx_n   = '0;
                        state_n = ST_INPUT;
                    end
                end
            end
            ST_INPUT: begin
                // A press outranks a timeout expiring in the same cycle.
                if (BTN != 4'b0000) begin
                    if (BTN == colour_mask(cur_colour)) begin
                        idx_n = idx + LEN_W'(1);
                        cnt_n = '0;
                        if (idx + LEN_W'(1) == len) begin
                            state_n = (len == LEN_W'(MAX_LEN)) ? ST_WIN : ST_ROUND_GAP;
                        end
                    end else begin
                        state_n = ST_LOSE;
                    end
                end else if (tick_done_to) begin
                    state_n = ST_LOSE;
                end
            end
            ST_ROUND_GAP: begin
                if (tick_done_gap) state_n = ST_APPEND;
            end
            ST_WIN, ST_LOSE: begin
                if (tick_done_res) begin
                    len_n   = '0;
                    idx_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state_n != state) cnt_n = '0;

        // On the first append the colour being written is also the first one shown.
        if (seq_we && (idx_n == len)) show_colour = lfsr[1:0];
        else                          show_colour = seq[idx_n[SEL_W-1:0]];
        if (state_n == ST_SHOW_ON) colour_n = colour_mask(show_colour);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            len      <= '0;
            idx      <= '0;
            cnt      <= '0;
            colour_q <= 4'b0000;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            pwr_q    <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            colour_q <= colour_n;
            win_q    <= (state_n == ST_WIN);
            lose_q   <= (state_n == ST_LOSE);
            pwr_q    <= (state_n != ST_IDLE);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (seq_we) seq[len[SEL_W-1:0]] <= lfsr[1:0];
    end

    assign BLUE_EN   = colour_q[COLOUR_BLUE];
    assign GREEN_EN  = colour_q[COLOUR_GREEN];
    assign RED_EN    = colour_q[COLOUR_RED];
    assign YELLOW_EN = colour_q[COLOUR_YELLOW];
    assign WIN_EN    = win_q;
    assign LOSE_EN   = lose_q;
    assign PWR_EN    = pwr_q;
    assign LEVEL     = len;
    assign fsm_state = state;

endmodule

// File: tb/tb_genius_sequencer.sv
// Bench for genius_sequencer: a frame-countdown game model predicts every output
// each cycle, while directed and random games exercise wins, losses and resets.
module tb_genius_sequencer;

    localparam int MAX_LEN  = 2;
    localparam int ON       = 2;
    localparam int GAP      = 1;
    localparam int TO       = 5;
    localparam int RES      = 3;
    localparam int TICK_DIV = 10;

    localparam int P_IDLE = 0, P_APPEND = 1, P_SHOW_ON = 2, P_SHOW_GAP = 3;
    localparam int P_INPUT = 4, P_ROUND_GAP = 5, P_WIN = 6, P_LOSE = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;

    logic       blue_en, green_en, red_en, yellow_en;
    logic       lose_en, win_en, pwr_en;
    logic [5:0] level;
    genius_pkg::state_t fsm_state;
    logic [3:0] colours;

    assign colours = {yellow_en, red_en, green_en, blue_en};

    genius_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .ON_FRAMES      (ON),
        .GAP_FRAMES     (GAP),
        .TIMEOUT_FRAMES (TO),
        .RESULT_FRAMES  (RES),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .FRAME_TICK (frame_tick),
        .START      (start),
        .BTN        (btn),
        .BLUE_EN    (blue_en),
        .GREEN_EN   (green_en),
        .RED_EN     (red_en),
        .YELLOW_EN  (yellow_en),
        .LOSE_EN    (lose_en),
        .WIN_EN     (win_en),
        .PWR_EN     (pwr_en),
        .LEVEL      (level),
        .fsm_state  (fsm_state)
    );

    // clock / reset / frame tick
    always #5 clk = ~clk;

    int tick_div = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_div   = 0;
            frame_tick = 1'b0;
        end else begin
            #1;
            tick_div   = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
            frame_tick = (tick_div == TICK_DIV - 1);
        end
    end

    // scoreboard bookkeeping
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_mask(input int c);
        return 4'(1 << c);
    endfunction

    // behavioural game model: phase, frames left in the phase, sequence queue
    int          m_phase = P_IDLE;
    int          m_left  = 0;
    int          m_pos   = 0;
    int          m_seq[$];
    logic [15:0] m_lfsr  = 16'hACE1;

    task automatic go(input int p, input int frames);
        m_phase = p;
        m_left  = frames;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        bit          done;
        cur    = m_lfsr;
        m_lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
        done   = 1'b0;
        if (frame_tick) begin
            m_left--;
            done = (m_left == 0);
        end
        case (m_phase)
            P_IDLE: if (start) begin
                m_seq.delete();
                m_pos = 0;
                go(P_APPEND, 0);
            end
            P_APPEND: begin
                m_seq.push_back(int'(cur[1:0]));
                m_pos = 0;
                go(P_SHOW_ON, ON);
            end
            P_SHOW_ON: if (done) go(P_SHOW_GAP, GAP);
            P_SHOW_GAP: if (done) begin
                m_pos++;
                if (m_pos < m_seq.size()) go(P_SHOW_ON, ON);
                else begin
                    m_pos = 0;
                    go(P_INPUT, TO);
                end
            end
            P_INPUT: begin
                if (btn != 4'b0000) begin
                    if (btn == col_mask(m_seq[m_pos])) begin
                        m_pos++;
                        if (m_pos == m_seq.size()) begin
                            if (m_seq.size() == MAX_LEN) go(P_WIN, RES);
                            else                         go(P_ROUND_GAP, GAP);
                        end else begin
                            m_left = TO;
                        end
                    end else begin
                        go(P_LOSE, RES);
                    end
                end else if (done) begin
                    go(P_LOSE, RES);
                end
            end
            P_ROUND_GAP: if (done) go(P_APPEND, 0);
            default: if (done) begin
                m_seq.delete();
                m_pos = 0;
                go(P_IDLE, 0);
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE;
            m_left  = 0;
            m_pos   = 0;
            m_seq.delete();
            m_lfsr  = 16'hACE1;
        end else begin
            model_step();
        end
    end

    // compare process: every cycle, after the edge has settled
    always @(posedge clk) begin
        logic [3:0] e_col;
        #3;
        e_col = (m_phase == P_SHOW_ON) ? col_mask(m_seq[m_pos]) : 4'b0000;
        check("colour", colours, e_col);
        check("win_en", win_en, (m_phase == P_WIN));
        check("lose_en", lose_en, (m_phase == P_LOSE));
        check("pwr_en", pwr_en, (m_phase != P_IDLE));
        check("level", level, m_seq.size());
    end

    // driver tasks: all start and end on a falling edge
    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        @(negedge clk);
        btn = 4'b0000;
    endtask

    task automatic wait_phase(input int p, input int budget, input string name);
        int n = 0;
        while (m_phase != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (m_phase == p), 1);
    endtask

    task automatic play_watch(output int spans, output int ticks);
        logic [3:0] prev = 4'b0000;
        int n = 0;
        spans = 0;
        ticks = 0;
        while (m_phase != P_INPUT && n < 1000) begin
            if (colours != 4'b0000) begin
                check("onehot", $countones(colours), 1);
                if (prev == 4'b0000) spans++;
                if (frame_tick) ticks++;
            end
            prev = colours;
            @(negedge clk);
            n++;
        end
        check("reach_input", (m_phase == P_INPUT), 1);
    endtask

    task automatic wait_colour();
        int n = 0;
        while (colours == 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("colour_seen", (colours != 4'b0000), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int spans, ticks, n, first_a, r, d;
        logic [3:0] b;

        repeat (3) @(negedge clk);
        check("reset_colour", colours, 0);
        check("reset_pwr", pwr_en, 0);
        check("reset_win", win_en, 0);
        check("reset_lose", lose_en, 0);
        check("reset_level", level, 0);
        rst = 1'b0;

        // two-round winning game
        idle_cycles(2);
        pulse_start();
        check("pwr_after_start", pwr_en, 1);
        @(negedge clk);
        check("level_round1", level, 1);
        play_watch(spans, ticks);
        check("round1_spans", spans, 1);
        check("round1_lit_ticks", ticks, 2);
        idle_cycles($urandom_range(0, 25));
        press(col_mask(m_seq[0]));
        check("level_in_gap", level, 1);
        play_watch(spans, ticks);
        check("level_round2", level, 2);
        check("round2_spans", spans, 2);
        check("round2_lit_ticks", ticks, 4);
        idle_cycles($urandom_range(0, 25));
        press(col_mask(m_seq[0]));
        idle_cycles($urandom_range(0, 25));
        press(col_mask(m_seq[1]));
        check("win_next_cycle", win_en, 1);
        ticks = 0;
        n = 0;
        while (win_en && n < 500) begin
            if (frame_tick) ticks++;
            @(negedge clk);
            n++;
        end
        check("win_ticks", ticks, 3);
        check("after_win_outputs", {colours, win_en, lose_en, pwr_en}, 0);
        check("after_win_level", level, 0);

        // wrong colour
        pulse_start();
        play_watch(spans, ticks);
        press(col_mask((m_seq[0] + 1) % 4));
        check("wrong_lose_next", lose_en, 1);
        wait_phase(P_IDLE, 200, "wrong_back_idle");
        check("wrong_idle_lose", lose_en, 0);

        // timeout with no press
        pulse_start();
        play_watch(spans, ticks);
        ticks = 0;
        n = 0;
        while (!lose_en && n < 200) begin
            if (frame_tick) ticks++;
            @(negedge clk);
            n++;
        end
        check("timeout_ticks", ticks, 5);
        wait_phase(P_IDLE, 200, "timeout_back_idle");

        // press on the cycle of the fifth tick
        pulse_start();
        play_watch(spans, ticks);
        ticks = 0;
        n = 0;
        while (n < 200) begin
            if (frame_tick) begin
                if (ticks == 4) break;
                ticks++;
            end
            @(negedge clk);
            n++;
        end
        check("fifth_tick_found", ticks, 4);
        press(col_mask(m_seq[0]));
        check("fifth_tick_no_lose", lose_en, 0);
        check("fifth_tick_pwr", pwr_en, 1);
        wait_phase(P_IDLE, 1000, "fifth_back_idle");

        // two buttons at once
        pulse_start();
        play_watch(spans, ticks);
        press(4'b0011);
        check("multi_btn_lose", lose_en, 1);
        wait_phase(P_IDLE, 200, "multi_back_idle");

        // START during playback is ignored
        pulse_start();
        wait_colour();
        idle_cycles(3);
        pulse_start();
        check("start_ignored_level", level, 1);
        check("start_ignored_colour", $countones(colours), 1);
        wait_phase(P_IDLE, 1000, "ignored_back_idle");

        // reset mid-playback, then replay with identical timing
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(7);
        pulse_start();
        wait_colour();
        first_a = m_seq[0];
        idle_cycles(3);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {colours, win_en, lose_en, pwr_en}, 0);
        check("async_reset_level", level, 0);
        @(negedge clk);
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(7);
        pulse_start();
        wait_colour();
        check("replay_colour", colours, col_mask(first_a));
        wait_phase(P_IDLE, 1000, "replay_back_idle");

        // random games
        for (int g = 0; g < 8; g++) begin
            idle_cycles($urandom_range(0, 20));
            pulse_start();
            n = 0;
            while (m_phase != P_IDLE && n < 4000) begin
                if (m_phase == P_INPUT) begin
                    r = $urandom_range(0, 9);
                    d = (r == 0) ? 60 : $urandom_range(0, 25);
                    idle_cycles(d);
                    n += d;
                    if (m_phase == P_INPUT) begin
                        if (r == 1) b = 4'($urandom_range(1, 15));
                        else        b = col_mask(m_seq[m_pos]);
                        press(b);
                    end
                    n++;
                end else begin
                    if ($urandom_range(0, 40) == 0) pulse_start();
                    else @(negedge clk);
                    n++;
                end
            end
            check("random_game_end", (m_phase == P_IDLE), 1);
        end

        idle_cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
